// File: rtl/session_ctrl.sv
// Session sequencer for a multi-round reaction-time measurement: arms the round FSM
// ROUNDS times with a fixed idle gap, accumulates results and reports best/average/misses.
module session_ctrl #(
   parameter int            ROUNDS       = 4,
   parameter int            GAP          = 12_500_000,
   parameter int            W            = 19,
   parameter logic [W-1:0]  MISS_PENALTY = 19'd100_000
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_start,
   input  logic                        i_done,
   input  logic                        i_miss,
   input  logic [W-1:0]                i_measured,
   output logic                        o_round_go,
   output logic [$clog2(ROUNDS)-1:0]   o_round_idx,
   output logic [W-1:0]                o_best,
   output logic [W-1:0]                o_avg,
   output logic [$clog2(ROUNDS):0]     o_misses,
   output logic                        o_busy,
   output logic                        o_session_done
);

   // state  | meaning
   // IDLE   | no session since reset
   // ARM    | o_round_go pulse, round FSM starting
   // WAIT   | waiting for i_done from the round FSM
   // GAP    | idle spacing between rounds
   // FINISH | average latched, o_session_done pulse
   // DONE   | session complete, results held

   localparam int IW = $clog2(ROUNDS);
   localparam int SW = W + IW;
   localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [IW:0]   MISS_ONE = 1;
   localparam logic [IW-1:0] IDX_ONE  = 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_WAIT, S_GAP, S_FINISH, S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   gap_cnt;
   logic [SW-1:0]   sum, sum_upd;
   logic            accept, last_round, begin_session;
   logic            go_nxt, busy_nxt, done_nxt;

   assign accept        = (state == S_WAIT) && i_done;
   assign last_round    = (o_round_idx == IDX_LAST);
   assign begin_session = ((state == S_IDLE) || (state == S_DONE)) && i_start;
   assign sum_upd       = sum + SW'(i_miss ? MISS_PENALTY : i_measured);

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (i_start) state_nxt = S_ARM;
         S_ARM:          state_nxt = S_WAIT;
         S_WAIT:         if (i_done) state_nxt = last_round ? S_FINISH : S_GAP;
         S_GAP:          if (gap_cnt == '0) state_nxt = S_ARM;
         S_FINISH:       state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up with the state.
   always_comb begin
      go_nxt   = (state_nxt == S_ARM);
      done_nxt = (state_nxt == S_FINISH);
      busy_nxt = (state_nxt == S_ARM) || (state_nxt == S_WAIT) ||
                 (state_nxt == S_GAP) || (state_nxt == S_FINISH);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_round_go     <= 1'b0;
         o_busy         <= 1'b0;
         o_session_done <= 1'b0;
         o_round_idx    <= '0;
         o_misses       <= '0;
         o_best         <= '1;
         o_avg          <= '1;
         sum            <= '0;
         gap_cnt        <= CW'(GAP - 1);
      end else begin
         o_round_go     <= go_nxt;
         o_busy         <= busy_nxt;
         o_session_done <= done_nxt;

         // Counter reloads whenever outside GAP, so it always enters GAP at GAP-1.
         if (state != S_GAP)       gap_cnt <= CW'(GAP - 1);
         else if (gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;

         if (begin_session) begin
            sum         <= '0;
            o_misses    <= '0;
            o_round_idx <= '0;
         end

         if (accept) begin
            sum <= sum_upd;
            if (i_miss)                  o_misses <= o_misses + MISS_ONE;
            else if (i_measured < o_best) o_best  <= i_measured;
            if (last_round) o_avg       <= W'(sum_upd >> IW);
            else            o_round_idx <= o_round_idx + IDX_ONE;
         end
      end
   end

endmodule

// File: tb/tb_session_ctrl.sv
// Directed bench for session_ctrl with ROUNDS=4, GAP=4, MISS_PENALTY=1000.
module tb_session_ctrl;
   localparam int W = 19;
   localparam logic [W-1:0] NONE = 19'h7FFFF;

   logic          clk = 1'b0;
   logic          i_rst = 1'b1, i_start = 1'b0, i_done = 1'b0, i_miss = 1'b0;
   logic [W-1:0]  i_measured = '0;
   logic          o_round_go, o_busy, o_session_done;
   logic [1:0]    o_round_idx;
   logic [W-1:0]  o_best, o_avg;
   logic [2:0]    o_misses;

   int total = 0, bad = 0;
   int go_cnt = 0, sd_cnt = 0;

   always #5 clk = ~clk;

   session_ctrl #(.ROUNDS(4), .GAP(4), .W(W), .MISS_PENALTY(19'd1000)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_done(i_done), .i_miss(i_miss),
      .i_measured(i_measured), .o_round_go(o_round_go), .o_round_idx(o_round_idx),
      .o_best(o_best), .o_avg(o_avg), .o_misses(o_misses), .o_busy(o_busy),
      .o_session_done(o_session_done)
   );

   always @(negedge clk) begin
      if (o_round_go === 1'b1)     go_cnt++;
      if (o_session_done === 1'b1) sd_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      i_start = 1'b1;
      tick;
      i_start = 1'b0;
   endtask

   task automatic wait_go(output int n);
      n = 0;
      while (o_round_go !== 1'b1 && n < 20) begin
         tick;
         n++;
      end
      chk("round_go_seen", 32'(o_round_go), 1);
   endtask

   task automatic finish_round(input logic [W-1:0] m, input logic miss);
      i_done = 1'b1; i_miss = miss; i_measured = m;
      tick;
      i_done = 1'b0; i_miss = 1'b0; i_measured = '0;
   endtask

   task automatic do_round(input logic [W-1:0] m, input logic miss, output int n);
      wait_go(n);
      tick;
      finish_round(m, miss);
   endtask

   initial begin
      logic [W-1:0] v [4];
      logic         mv [4];
      int n, g0, s0;

      // Reset
      tick; tick;
      i_rst = 1'b0;
      chk("rst_best", 32'(o_best), 32'(NONE));
      chk("rst_avg", 32'(o_avg), 32'(NONE));
      chk("rst_misses", 32'(o_misses), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_idx", 32'(o_round_idx), 0);
      tick; tick;
      chk("rst_no_go", go_cnt, 0);
      chk("rst_no_done", sd_cnt, 0);

      // Normal session 100,200,300,400
      v = '{19'd100, 19'd200, 19'd300, 19'd400};
      g0 = go_cnt; s0 = sd_cnt;
      pulse_start;
      for (int i = 0; i < 4; i++) begin
         do_round(v[i], 1'b0, n);
         if (i > 0) chk("go_spacing", n, 4);
         if (i < 3) chk("idx_after_round", 32'(o_round_idx), 32'(i + 1));
      end
      chk("s1_done_pulse", 32'(o_session_done), 1);
      chk("s1_avg", 32'(o_avg), 250);
      chk("s1_busy_finish", 32'(o_busy), 1);
      tick;
      chk("s1_done_low", 32'(o_session_done), 0);
      chk("s1_busy_done", 32'(o_busy), 0);
      tick; tick;
      chk("s1_best", 32'(o_best), 100);
      chk("s1_misses", 32'(o_misses), 0);
      chk("s1_go_count", go_cnt - g0, 4);
      chk("s1_done_count", sd_cnt - s0, 1);

      // Miss session with ignored-input probes
      g0 = go_cnt; s0 = sd_cnt;
      pulse_start;
      chk("s2_misses_clear", 32'(o_misses), 0);
      chk("s2_idx_clear", 32'(o_round_idx), 0);
      wait_go(n);
      tick;
      i_start = 1'b1; tick; i_start = 1'b0;
      chk("ign_start_busy", 32'(o_busy), 1);
      chk("ign_start_idx", 32'(o_round_idx), 0);
      i_miss = 1'b1; tick; i_miss = 1'b0;
      tick;
      chk("ign_start_no_go", go_cnt - g0, 1);
      finish_round(19'd100, 1'b0);
      i_done = 1'b1; i_measured = 19'd5; tick; i_done = 1'b0; i_measured = '0;
      chk("ign_gap_best", 32'(o_best), 100);
      chk("ign_gap_idx", 32'(o_round_idx), 1);
      do_round(19'd0, 1'b1, n);
      do_round(19'd300, 1'b0, n);
      do_round(19'd400, 1'b0, n);
      chk("s2_avg", 32'(o_avg), 450);
      tick; tick;
      chk("s2_best", 32'(o_best), 100);
      chk("s2_misses", 32'(o_misses), 1);
      chk("s2_go_count", go_cnt - g0, 4);
      chk("s2_done_count", sd_cnt - s0, 1);
      i_done = 1'b1; i_measured = 19'd3; tick; i_done = 1'b0; i_measured = '0;
      tick; tick;
      chk("ign_idle_best", 32'(o_best), 100);
      chk("ign_idle_busy", 32'(o_busy), 0);
      chk("ign_idle_avg", 32'(o_avg), 450);
      chk("ign_idle_no_go", go_cnt - g0, 4);

      // All-miss session after reset, then 50s
      i_rst = 1'b1; tick; tick; i_rst = 1'b0;
      chk("rst2_avg", 32'(o_avg), 32'(NONE));
      pulse_start;
      for (int i = 0; i < 4; i++) do_round(19'd7, 1'b1, n);
      tick; tick;
      chk("s3_best", 32'(o_best), 32'(NONE));
      chk("s3_avg", 32'(o_avg), 1000);
      chk("s3_misses", 32'(o_misses), 4);
      mv = '{1'b0, 1'b0, 1'b0, 1'b0};
      pulse_start;
      for (int i = 0; i < 4; i++) do_round(19'd50, mv[i], n);
      tick; tick;
      chk("s4_best", 32'(o_best), 50);
      chk("s4_avg", 32'(o_avg), 50);
      chk("s4_misses", 32'(o_misses), 0);

      // Mid-session reset in GAP
      pulse_start;
      do_round(19'd20, 1'b0, n);
      chk("mid_pre_busy", 32'(o_busy), 1);
      i_rst = 1'b1; tick; i_rst = 1'b0;
      chk("mid_busy", 32'(o_busy), 0);
      chk("mid_idx", 32'(o_round_idx), 0);
      chk("mid_best", 32'(o_best), 32'(NONE));
      tick;
      g0 = go_cnt; s0 = sd_cnt;
      repeat (10) tick;
      chk("mid_no_go", go_cnt - g0, 0);
      chk("mid_no_done", sd_cnt - s0, 0);
      chk("mid_busy_after", 32'(o_busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/session_ctrl.md
SESSION_CTRL -- requirements
Module: session_ctrl

Interface
REQ-001 Parameter: ROUNDS, default 4, rounds per session; power of two, 2..8.
REQ-002 Parameter: GAP, default 12_500_000, idle clock cycles between rounds; must be at least 1.
REQ-003 Parameter: W, default 19, width of the measured-time datapath.
REQ-004 Parameter: MISS_PENALTY, default 19'd100_000, value accumulated for a missed round.
REQ-005 Port: i_clk, input, 1, the single clock; the block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-006 Port: i_rst, input, 1, synchronous active-high reset.
REQ-007 Port: i_start, input, 1, one-cycle request to begin a session.
REQ-008 Port: i_done, input, 1, one-cycle pulse from the round FSM when a round ends.
REQ-009 Port: i_miss, input, 1, round was a miss; qualified by i_done.
REQ-010 Port: i_measured, input, W, reaction time; valid only when i_done=1 and i_miss=0.
REQ-011 Port: o_round_go, output, 1, one-cycle pulse that arms the round FSM.
REQ-012 Port: o_round_idx, output, log2(ROUNDS), index of the current round.
REQ-013 Port: o_best, output, W, minimum non-miss time since reset; all-ones means none.
REQ-014 Port: o_avg, output, W, average of the last completed session; all-ones means none.
REQ-015 Port: o_misses, output, log2(ROUNDS)+1, miss count for the current or last session.
REQ-016 Port: o_busy, output, 1, session in progress.
REQ-017 Port: o_session_done, output, 1, one-cycle pulse at the end of a session.

Function
REQ-018 The FSM SHALL have the states IDLE, ARM, WAIT, GAP, FINISH and DONE.
REQ-019 IDLE/DONE + i_start -> ARM next cycle; sum, o_misses and o_round_idx clear; o_best and o_avg are retained.
REQ-020 ARM SHALL assert o_round_go for exactly that one cycle, then go to WAIT.
REQ-021 WAIT + i_done -> the next cycle SHALL hold the update and a state change.
REQ-022 Non-miss round: sum += i_measured, and o_best = min(o_best, i_measured).
REQ-023 Miss round: sum += MISS_PENALTY, o_misses increments, and o_best is unchanged.
REQ-024 After the update, if o_round_idx = ROUNDS-1 the FSM SHALL go to FINISH; otherwise o_round_idx increments and the FSM goes to GAP.
REQ-025 GAP SHALL load its counter with GAP-1 on entry, count down to 0, then go to ARM, giving exactly GAP cycles in GAP.
REQ-026 The sum register SHALL be W+log2(ROUNDS) bits wide, so no overflow is possible; no saturation logic.
REQ-027 FINISH (one cycle): o_avg = sum >> log2(ROUNDS), truncating; o_session_done=1; next state DONE.
REQ-028 o_busy SHALL be 1 in ARM, WAIT, GAP and FINISH, and 0 in IDLE and DONE.
REQ-029 i_start SHALL be ignored outside IDLE and DONE; i_done SHALL be ignored outside WAIT; i_miss without i_done SHALL be ignored.
REQ-030 i_start and i_done in the same cycle: each is handled per its state rule only; no conflict is possible.
REQ-031 All outputs SHALL be registered; none may depend combinationally on an input.

Reset
REQ-032 When i_rst=1, the next clock SHALL set: state IDLE, o_best and o_avg all-ones, sum/o_misses/o_round_idx 0, and o_round_go/o_busy/o_session_done 0.
REQ-033 Reset mid-session, in any state, SHALL abort the session; no o_round_go or o_session_done may follow until a new i_start.
REQ-034 Reset SHALL take priority over every other input in the same cycle.

Verification (bench: ROUNDS=4, GAP=4, MISS_PENALTY=1000)
REQ-035 Reset: assert i_rst for 2 cycles -> o_best=0x7FFFF, o_avg=0x7FFFF, o_misses=0, o_busy=0, no pulses.
REQ-036 Normal session: i_start, then rounds 100, 200, 300, 400 -> o_best=100, o_avg=250, o_misses=0, a single o_session_done pulse; o_round_go pulses exactly 4 times, spaced by 4 GAP cycles plus 1 ARM cycle.
REQ-037 Miss session: rounds 100, miss, 300, 400 -> sum 1800, o_avg=450, o_best=100, o_misses=1.
REQ-038 All-miss session after reset: o_best stays 0x7FFFF, o_avg=1000, o_misses=4; a second session of 50, 50, 50, 50 -> o_best=50, o_avg=50.
REQ-039 Ignored inputs: i_start during WAIT and i_done during GAP or IDLE -> no state, sum or index change, and no extra o_round_go.
REQ-040 Mid-session reset: i_rst in GAP after round 1 -> IDLE, o_round_idx=0, o_busy=0, and no o_round_go for 10 following cycles.
